// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seconds display.
// Segment codes, digit strobes, BCD limits.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] DIG_ONES = 2'b01;
   localparam logic [1:0] DIG_TENS = 2'b10;

   localparam logic [3:0] BCD_TENS_MAX = 4'd5;
   localparam logic [3:0] BCD_ONES_MAX = 4'd9;

   function automatic logic bcd_sec_valid(input logic [7:0] v);
      return (v[7:4] <= BCD_TENS_MAX) && (v[3:0] <= BCD_ONES_MAX);
   endfunction

endpackage

// File: rtl/seg7_seconds_display_decoder.sv
// seg7_decoder: combinational BCD digit to segment pattern.
// Non-decimal codes show a blank digit.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // one pattern per decimal digit, blank otherwise
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_seconds_display.sv
// seg7_seconds_display: 1 Hz BCD seconds with 2-digit muxed display.
// Optional SEG7_DP_BLINK_EN: 1 Hz decimal-point blink on ones digit.
module seg7_seconds_display
   import seg7_pkg::*;
#(
   parameter int CLK_HZ  = 10_000_000,
   parameter int MUX_DIV = 10_000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pause,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] digit_sel,
   output logic [7:0] sec_bcd,
   output logic       min_pulse
);

   localparam int PW = (CLK_HZ  > 2) ? $clog2(CLK_HZ)  : 1;
   localparam int MW = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
   localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [MW-1:0] r_mux;
   logic [7:0]    r_sec;
   logic [1:0]    r_dsel;
   logic          r_min_pulse;

   logic          w_run;
   logic          w_load;
   logic          w_tick;
   logic          w_wrap;
   logic [3:0]    w_digit;
   logic [6:0]    w_dec;

   assign w_run  = ena & ~pause;
   assign w_load = load & ena;
   assign w_tick = w_run & (r_presc == PRE_LAST);
   // a load in the tick cycle swallows the tick and its wrap
   assign w_wrap = w_tick & ~w_load & (r_sec == 8'h59);

   // prescaler: divide to one tick per second, restart on load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_load) begin
         r_presc <= '0;
      end else if (w_run) begin
         if (r_presc == PRE_LAST) r_presc <= '0;
         else                     r_presc <= r_presc + 1'b1;
      end
   end

   // BCD seconds: load with validity check, else advance on tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sec <= 8'h00;
      end else if (w_load) begin
         r_sec <= bcd_sec_valid(load_val) ? load_val : 8'h00;
      end else if (w_tick) begin
         if (r_sec[3:0] == BCD_ONES_MAX) begin
            r_sec[3:0] <= 4'd0;
            if (r_sec[7:4] == BCD_TENS_MAX) r_sec[7:4] <= 4'd0;
            else                            r_sec[7:4] <= r_sec[7:4] + 4'd1;
         end else begin
            r_sec[3:0] <= r_sec[3:0] + 4'd1;
         end
      end
   end

   // minute pulse, registered one cycle after the 59->00 edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_min_pulse <= 1'b0;
      else        r_min_pulse <= w_wrap;
   end

   // digit multiplexer: hold each digit MUX_DIV cycles while enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mux  <= '0;
         r_dsel <= DIG_ONES;
      end else if (ena) begin
         if (r_mux == MUX_LAST) begin
            r_mux  <= '0;
            r_dsel <= (r_dsel == DIG_ONES) ? DIG_TENS : DIG_ONES;
         end else begin
            r_mux <= r_mux + 1'b1;
         end
      end
   end

   // pick the strobed digit for the shared decoder
   always_comb begin
      w_digit = r_sec[3:0];
      if (r_dsel == DIG_TENS) w_digit = r_sec[7:4];
   end

   seg7_decoder u_dec (
      .i_bcd (w_digit),
      .o_seg (w_dec)
   );

   assign seg       = ena ? w_dec : SEG_BLANK;
   assign digit_sel = r_dsel;
   assign sec_bcd   = r_sec;
   assign min_pulse = r_min_pulse;

`ifdef SEG7_DP_BLINK_EN
   localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
   assign dp = ena & (r_dsel == DIG_ONES) & (r_presc < PRE_HALF);
`else
   assign dp = 1'b0;
`endif

endmodule
